// File: rtl/spi_slave_word_if.sv
// SPI slave with oversampled pins, configurable width/mode/bit order, a received-word
// strobe and a one-deep handshaked transmit holding register, all in the CLOCK_Y2 domain.
module spi_slave_word_if #(
   parameter int               WIDTH     = 8,
   parameter bit               CPOL      = 1'b0,
   parameter bit               CPHA      = 1'b0,
   parameter bit               MSB_FIRST = 1'b1,
   parameter logic [WIDTH-1:0] TX_FILL   = '1
) (
   input  logic             CLOCK_Y2,
   input  logic             RST_N,
   input  logic             SCK,
   input  logic             MOSI,
   input  logic             SS,
   output logic             MISO,
   output logic             MISO_OE,
   output logic [WIDTH-1:0] RX_DATA,
   output logic             RX_VALID,
   input  logic [WIDTH-1:0] TX_DATA,
   input  logic             TX_VALID,
   output logic             TX_READY,
   output logic             TX_UNDERRUN,
   output logic             BUSY,
   output logic             LED1
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;
   state_t state, state_nx;

   logic [1:0]       sck_sync, mosi_sync, ss_sync;
   logic             sck_d, sck_s, mosi_s, ss_s;
   logic             rise, fall, lead, trail, sample_e, shift_e;
   logic             ss_fall, act, abort, load, accept;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rx_sr, rx_nx, tx_sr, tx_nx, hold;
   logic             hold_full;

   always_ff @(posedge CLOCK_Y2) begin
      if (!RST_N) begin
         sck_sync  <= {2{CPOL}};
         mosi_sync <= '0;
         // SS reads low until truly seen high, so a frame cut by reset stays ignored
         ss_sync   <= '0;
         sck_d     <= CPOL;
      end else begin
         sck_sync  <= {sck_sync[0], SCK};
         mosi_sync <= {mosi_sync[0], MOSI};
         ss_sync   <= {ss_sync[0], SS};
         sck_d     <= sck_sync[1];
      end
   end

   assign sck_s    = sck_sync[1];
   assign mosi_s   = mosi_sync[1];
   assign ss_s     = ss_sync[1];
   assign rise     = sck_s & ~sck_d;
   assign fall     = ~sck_s & sck_d;
   assign lead     = CPOL ? fall : rise;
   assign trail    = CPOL ? rise : fall;
   assign sample_e = CPHA ? trail : lead;
   assign shift_e  = CPHA ? lead : trail;

   always_ff @(posedge CLOCK_Y2) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ss_fall  = 1'b0;
      act      = 1'b0;
      abort    = 1'b0;
      case (state)
         IDLE:   if (ss_s) state_nx = ARMED;
         ARMED:  if (!ss_s) begin
                    state_nx = ACTIVE;
                    ss_fall  = 1'b1;
                 end
         ACTIVE: if (ss_s) begin
                    state_nx = ARMED;
                    abort    = 1'b1;
                 end else begin
                    act = 1'b1;
                 end
         default: state_nx = IDLE;
      endcase
   end

   assign rx_nx = MSB_FIRST ? {rx_sr[WIDTH-2:0], mosi_s} : {mosi_s, rx_sr[WIDTH-1:1]};
   assign tx_nx = MSB_FIRST ? {tx_sr[WIDTH-2:0], 1'b0}   : {1'b0, tx_sr[WIDTH-1:1]};

   // A shift edge with the counter at zero can only be the start of a fresh word
   assign load   = (!CPHA && ss_fall) || (act && shift_e && cnt == '0);
   assign accept = TX_VALID && (!hold_full || load);

   always_ff @(posedge CLOCK_Y2) begin
      if (!RST_N) begin
         cnt         <= '0;
         rx_sr       <= '0;
         tx_sr       <= '0;
         hold        <= '0;
         hold_full   <= 1'b0;
         RX_DATA     <= '0;
         RX_VALID    <= 1'b0;
         TX_UNDERRUN <= 1'b0;
         LED1        <= 1'b0;
      end else begin
         RX_VALID    <= 1'b0;
         TX_UNDERRUN <= 1'b0;
         if (abort) begin
            cnt <= '0;
         end else if (act && sample_e) begin
            rx_sr <= rx_nx;
            if (cnt == LAST) begin
               RX_DATA  <= rx_nx;
               RX_VALID <= 1'b1;
               LED1     <= ~LED1;
               cnt      <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (load) begin
            if (hold_full) begin
               tx_sr <= hold;
            end else begin
               tx_sr       <= TX_FILL;
               TX_UNDERRUN <= 1'b1;
            end
         end else if (act && shift_e) begin
            tx_sr <= tx_nx;
         end
         // Accept on the load cycle too, so the holding register refills without a gap
         if (accept) begin
            hold      <= TX_DATA;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end
      end
   end

   assign MISO     = MSB_FIRST ? tx_sr[WIDTH-1] : tx_sr[0];
   assign MISO_OE  = (state == ACTIVE);
   assign BUSY     = (state == ACTIVE) && (cnt != '0);
   assign TX_READY = !hold_full;

endmodule
